// File: rtl/hex_scan_controller.sv
// hex_scan_controller: time-multiplexed seven-segment scan with a double-buffered BCD word
module hex_scan_controller #(
   parameter int DIGITS = 4,
   parameter int SCAN_DIV = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iValid,
   output logic                oReady,
   input  logic [4*DIGITS-1:0] iData,
   input  logic [DIGITS-1:0]   iDigitEn,
   output logic [6:0]          oSeg,
   output logic [DIGITS-1:0]   oDig,
   output logic                oFrame
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
      7'h7F, 7'h67, 7'h3E, 7'h3E, 7'h3E, 7'h3E, 7'h3E, 7'h3E
   };
   typedef enum logic {BLANK, SHOW} phase_t;
   phase_t              phase, phaseNext;
   logic [IW-1:0]       idx, idxNext;
   logic [SW-1:0]       slot, slotNext;
   logic [4*DIGITS-1:0] pendWord, dispWord, dispNext;
   logic                pendFlag, commit, lit, slotEnd;
   logic [3:0]          nib;
   // Outputs are registered from next-state values so they line up with the slot counter.
   always_comb begin
      slotEnd = slot == SW'(SCAN_DIV - 1);
      slotNext = slotEnd ? '0 : slot + 1'b1;
      idxNext = !slotEnd ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      phaseNext = phase == BLANK ? (slotNext == SW'(BLANK_CYC) ? SHOW : BLANK)
                                 : (slotNext == '0 ? BLANK : SHOW);
      commit = oFrame && pendFlag;
      dispNext = commit ? pendWord : dispWord;
      nib = dispNext[{idxNext, 2'b00} +: 4];
      lit = phaseNext == SHOW && iDigitEn[idxNext];
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         phase <= BLANK;
         idx <= '0;
         slot <= '0;
         dispWord <= '0;
         pendWord <= '0;
         pendFlag <= 1'b0;
         oFrame <= 1'b0;
         oSeg <= 7'h7F;
         oDig <= '1;
      end else begin
         phase <= phaseNext;
         idx <= idxNext;
         slot <= slotNext;
         dispWord <= dispNext;
         // commit only happens with the flag set, so it never coincides with a capture
         pendFlag <= commit ? 1'b0 : (iValid && !pendFlag) ? 1'b1 : pendFlag;
         if (iValid && !pendFlag) pendWord <= iData;
         oFrame <= idxNext == IW'(DIGITS - 1) && slotNext == SW'(SCAN_DIV - 1);
         oSeg <= lit ? ~GLYPH[nib] : 7'h7F;
         oDig <= lit ? ~(DIGITS'(1) << idxNext) : '1;
      end
   end
   assign oReady = !pendFlag;
endmodule

// File: doc/hex_scan_controller.md
# hex_scan_controller

Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one segment bus. It accepts a packed BCD word through a valid/ready handshake, double-buffers it so that updates land only at frame boundaries, and cycles through the digits with a programmable dwell and anti-ghosting blank interval. Each digit's nibble is decoded internally with the team's standard 0–9 / 'U' glyph set, active-low. It sits between the numeric datapath (counters, BCD converters) and the board's HEX pins.

## Interface
- DIGITS, 4: number of scanned digits (1–8).
- SCAN_DIV, 50000: clock cycles per digit slot (blank + show); must exceed BLANK_CYC.
- BLANK_CYC, 16: cycles at the start of each slot with all outputs off (≥1).
- iClk  in  1  system clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iValid  in  1  iData holds a new display word.
- oReady  out  1  controller can accept a word; transfer when iValid && oReady at a rising edge.
- iData  in  4*DIGITS  packed nibbles; [3:0] = digit 0 (rightmost).
- iDigitEn  in  DIGITS  per-digit enable mask, sampled live; 0 = digit dark in its slot.
- oSeg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- oDig  out  DIGITS  digit anode selects, active-low, at most one low at any time.
- oFrame  out  1  one-cycle pulse on the last cycle of each full scan frame.

## Operation
- Registers: pending word + pending flag, display word, digit index (0..DIGITS-1), slot counter (0..SCAN_DIV-1), phase state.
- Phase FSM, two states: BLANK (slot counter 0..BLANK_CYC-1) → SHOW (BLANK_CYC..SCAN_DIV-1) → BLANK of next digit; index wraps DIGITS-1 → 0.
- BLANK: oSeg = 7'h7F, oDig all ones.
- SHOW: oSeg = decode(display nibble[index]); oDig bit index low iff iDigitEn[index], else all ones and oSeg = 7'h7F. Disabled digits keep their full slot length (uniform brightness).
- Decode before inversion: 0→3F,1→06,2→5B,3→4F,4→66,5→6D,6→7D,7→27,8→7F,9→67, 10–15→3E ('U'); oSeg is bitwise inverse.
- Handshake: oReady = !pending flag. Transfer captures iData into pending, sets flag.
- Commit: on the cycle oFrame is high, if flag set, display ← pending and flag clears. A transfer occurring on the oFrame cycle itself is not committed until the following frame end.
- iValid while oReady low is ignored; iData need not be held.

## Timing
- Reset (iRst high at an edge): next cycle oSeg = 7'h7F, oDig all ones, oReady = 1, oFrame = 0, index 0, slot counter 0, BLANK, display word 0, pending discarded. Reset mid-slot or mid-handshake aborts immediately, no partial commit.
- All outputs registered; frame length = DIGITS*SCAN_DIV cycles.
- First cycle after reset release = slot cycle 0 of digit 0 (BLANK); digit 0 lit from cycle BLANK_CYC.
- oFrame high on cycle DIGITS*SCAN_DIV-1 of each frame (digit DIGITS-1, slot cycle SCAN_DIV-1).
- oReady falls the cycle after a transfer; rises the cycle after the committing oFrame.
- New word first visible at digit 0 show phase of the next frame: BLANK_CYC cycles after the oFrame pulse.
- iDigitEn change takes effect on the next cycle without waiting for a frame.

## Test plan
Use DIGITS=4, SCAN_DIV=8, BLANK_CYC=2 (frame = 32 cycles).
- Reset then idle: oSeg=7'h7F, oDig=4'hF for cycles 0–1; cycle 2 oDig=4'b1110, oSeg=7'h40 ('0'); oFrame only on cycles 31, 63, …
- Load 16'h9876 at cycle 5: oReady low cycles 6–31, high at 32; cycle 34 digit 0 shows 7'h02 ('6'); cycle 42 oDig=4'b1101, oSeg=7'h58 ('7'); cycle 58 digit 3 oSeg=7'h18 ('9').
- Load 16'hFA03: digit 0 → 7'h30, digit 1 → 7'h40, digits 2–3 → 7'h41 ('U').
- iDigitEn=4'b0101: slots for digits 1 and 3 keep oDig=4'hF, oSeg=7'h7F, digits 0/2 lit; slot timing unchanged.
- Transfer exactly on an oFrame cycle: display unchanged that frame, oReady low until the next oFrame, commit then; second iValid while oReady low is dropped.
- Assert iRst during SHOW of digit 2 with a pending word: next cycle all dark, oReady=1, old pending never displayed, scan restarts at digit 0; check oDig never has two bits low throughout.
